mmss_timekeeper: RTL and testbench

- Minutes:seconds timekeeping core for the stopwatch/clock display path.
- Consumes the debounced single-cycle button pulses and the 1 Hz enable strobe.
- Holds run/stop state and produces registered BCD digits that drive the four seven-segment decoders directly.
- Provides a minute-wrap carry for a future hours stage.

---
 rtl/clock_pkg.sv | 16 +
 rtl/bcd_mod_cnt.sv | 68 ++++++
 rtl/mmss_timekeeper.sv | 104 ++++++++++
 tb/tb_mmss_timekeeper.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and types for the mm:ss timekeeping path.
// Digit limits, run/stop state encoding and the BCD digit type.
package clock_pkg;

    localparam int SEC_MAX_H = 5;
    localparam int SEC_MAX_L = 9;
    localparam int BCD_MAX   = 9;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter (tens 3 bits, units BCD).
// Wraps to 00 after MAX_H:MAX_L; WRAP flags an increment at terminal.
module bcd_mod_cnt
    import clock_pkg::*;
#(
    parameter int MAX_H = 5,
    parameter int MAX_L = 9
)
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLR,
    input  logic       INC,
    output logic [2:0] QH,
    output bcd_t       QL,
    output logic       WRAP
);

    localparam logic [2:0] LP_MAX_H = 3'(MAX_H);
    localparam bcd_t       LP_MAX_L = 4'(MAX_L);
    localparam bcd_t       LP_BCD_9 = 4'(BCD_MAX);

    logic [2:0] r_qh;
    bcd_t       r_ql;
    logic [2:0] w_qh_nxt;
    bcd_t       w_ql_nxt;
    logic       w_at_max;
    logic       w_ql_top;

    assign w_at_max = (r_qh == LP_MAX_H) && (r_ql == LP_MAX_L);
    assign w_ql_top = (r_ql == LP_BCD_9);

    // Next digit values for one increment, wrapping only at terminal.
    always_comb begin
        w_qh_nxt = r_qh;
        w_ql_nxt = r_ql;
        if (INC) begin
            if (w_at_max) begin
                w_qh_nxt = '0;
                w_ql_nxt = '0;
            end else if (w_ql_top) begin
                w_qh_nxt = r_qh + 3'd1;
                w_ql_nxt = '0;
            end else begin
                w_ql_nxt = r_ql + 4'd1;
            end
        end
    end

    // Digit registers: reset, then clear, then increment.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_qh <= '0;
            r_ql <= '0;
        end else if (CLR) begin
            r_qh <= '0;
            r_ql <= '0;
        end else begin
            r_qh <= w_qh_nxt;
            r_ql <= w_ql_nxt;
        end
    end

    assign QH   = r_qh;
    assign QL   = r_ql;
    assign WRAP = INC & w_at_max;

endmodule

// File: rtl/mmss_timekeeper.sv
// Minutes:seconds timekeeper with run/stop FSM and wrap carry.
// Buttons outrank the 1 Hz tick; CLR outranks everything but reset.
module mmss_timekeeper
    import clock_pkg::*;
#(
    parameter int MIN_MAX = 59
)
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN1HZ,
    input  logic       CLR,
    input  logic       STARTSTOP,
    input  logic       MINUP,
    input  logic       SECUP,
    output logic [3:0] SECL,
    output logic [2:0] SECH,
    output logic [3:0] MINL,
    output logic [2:0] MINH,
    output logic       RUNNING,
    output logic       CA
);

    localparam int LP_MIN_H = MIN_MAX / 10;
    localparam int LP_MIN_L = MIN_MAX % 10;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_ca;
    logic   w_ca_nxt;
    logic   w_btn;
    logic   w_tick;
    logic   w_sec_inc;
    logic   w_min_inc;
    logic   w_sec_wrap;
    logic   w_min_wrap;
    bcd_t   w_secl;
    bcd_t   w_minl;

    // A button pulse drops the tick; STOP ignores it entirely.
    assign w_btn     = MINUP | SECUP;
    assign w_tick    = EN1HZ & (r_state == RUN) & ~CLR & ~w_btn;
    assign w_sec_inc = ~CLR & (SECUP | w_tick);
    assign w_min_inc = ~CLR & (MINUP | (w_tick & w_sec_wrap));

    bcd_mod_cnt #(
        .MAX_H (SEC_MAX_H),
        .MAX_L (SEC_MAX_L)
    ) u_sec (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (CLR),
        .INC  (w_sec_inc),
        .QH   (SECH),
        .QL   (w_secl),
        .WRAP (w_sec_wrap)
    );

    bcd_mod_cnt #(
        .MAX_H (LP_MIN_H),
        .MAX_L (LP_MIN_L)
    ) u_min (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (CLR),
        .INC  (w_min_inc),
        .QH   (MINH),
        .QL   (w_minl),
        .WRAP (w_min_wrap)
    );

    // Run/stop toggle; CLR leaves the state alone.
    always_comb begin
        w_state_nxt = r_state;
        if (STARTSTOP) begin
            w_state_nxt = (r_state == RUN) ? STOP : RUN;
        end
    end

    // Carry only on a tick-driven rollover of both fields.
    always_comb begin
        w_ca_nxt = 1'b0;
        if (w_tick && w_sec_wrap && w_min_wrap) begin
            w_ca_nxt = 1'b1;
        end
    end

    // State and carry registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= STOP;
            r_ca    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ca    <= w_ca_nxt;
        end
    end

    assign SECL    = w_secl;
    assign MINL    = w_minl;
    assign RUNNING = (r_state == RUN);
    assign CA      = r_ca;

endmodule

// File: tb/tb_mmss_timekeeper.sv
// Scoreboard bench for mmss_timekeeper, MIN_MAX=59 and MIN_MAX=9.
// Expected outputs come from an integer model of both instances.
module tb_mmss_timekeeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, ss, mu, su;

    logic [3:0] secl_a, minl_a, secl_b, minl_b;
    logic [2:0] sech_a, minh_a, sech_b, minh_b;
    logic       run_a, ca_a, run_b, ca_b;

    typedef struct {
        logic [15:0] e59;
        logic [15:0] e9;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int m_sec[2];
    int m_min[2];
    int m_run[2];
    int m_ca[2];

    always #5 clk = ~clk;

    mmss_timekeeper #(.MIN_MAX(59)) dut59 (
        .CLK(clk), .RST(rst_n), .EN1HZ(en), .CLR(clr),
        .STARTSTOP(ss), .MINUP(mu), .SECUP(su),
        .SECL(secl_a), .SECH(sech_a), .MINL(minl_a), .MINH(minh_a),
        .RUNNING(run_a), .CA(ca_a)
    );

    mmss_timekeeper #(.MIN_MAX(9)) dut9 (
        .CLK(clk), .RST(rst_n), .EN1HZ(en), .CLR(clr),
        .STARTSTOP(ss), .MINUP(mu), .SECUP(su),
        .SECL(secl_b), .SECH(sech_b), .MINL(minl_b), .MINH(minh_b),
        .RUNNING(run_b), .CA(ca_b)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%04h exp=%04h (mm:ss run ca packed)",
                     tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pack(input int k);
        pack = {3'(m_min[k] / 10), 4'(m_min[k] % 10),
                3'(m_sec[k] / 10), 4'(m_sec[k] % 10),
                1'(m_run[k]), 1'(m_ca[k])};
    endfunction

    task automatic model(input logic r, e, c, s, mi, se);
        int mx;
        for (int k = 0; k < 2; k++) begin
            mx = (k == 0) ? 59 : 9;
            m_ca[k] = 0;
            if (!r) begin
                m_sec[k] = 0;
                m_min[k] = 0;
                m_run[k] = 0;
            end else begin
                if (c) begin
                    m_sec[k] = 0;
                    m_min[k] = 0;
                end else if (mi || se) begin
                    if (se) m_sec[k] = (m_sec[k] + 1) % 60;
                    if (mi) m_min[k] = (m_min[k] + 1) % (mx + 1);
                end else if (e && m_run[k] != 0) begin
                    m_sec[k]++;
                    if (m_sec[k] == 60) begin
                        m_sec[k] = 0;
                        m_min[k]++;
                        if (m_min[k] > mx) begin
                            m_min[k] = 0;
                            m_ca[k]  = 1;
                        end
                    end
                end
                if (s) m_run[k] = (m_run[k] != 0) ? 0 : 1;
            end
        end
    endtask

    task automatic cyc(input logic r, e, c, s, mi, se, input string tag);
        exp_t ex;
        rst_n = r; en = e; clr = c; ss = s; mu = mi; su = se;
        model(r, e, c, s, mi, se);
        ex.e59 = pack(0);
        ex.e9  = pack(1);
        q.push_back(ex);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd0, 16'd1);
        end else begin
            ex = q.pop_front();
            chk({tag, "_m59"},
                {minh_a, minl_a, sech_a, secl_a, run_a, ca_a}, ex.e59);
            chk({tag, "_m9"},
                {minh_b, minl_b, sech_b, secl_b, run_b, ca_b}, ex.e9);
        end
    endtask

    task automatic idle(input string tag);
        cyc(1, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic tick(input string tag);
        cyc(1, 1, 0, 0, 0, 0, tag);
        idle(tag);
    endtask

    task automatic minup(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 1, 0, "minup");
    endtask

    task automatic secup(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 1, "secup");
    endtask

    task automatic ensure_run(input logic want);
        if ((m_run[0] != 0) != want) cyc(1, 0, 0, 1, 0, 0, "toggle");
    endtask

    initial begin
        rst_n = 0; en = 0; clr = 0; ss = 0; mu = 0; su = 0;
        for (int k = 0; k < 2; k++) begin
            m_sec[k] = 0; m_min[k] = 0; m_run[k] = 0; m_ca[k] = 0;
        end
        @(negedge clk);

        for (int i = 0; i < 3; i++)
            cyc(0, 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), "reset");

        for (int i = 0; i < 5; i++) tick("stop_tick");

        cyc(1, 0, 0, 1, 0, 0, "start");
        for (int i = 0; i < 60; i++) tick("run_tick");

        cyc(1, 0, 1, 0, 0, 0, "clr");
        minup(59);
        secup(58);
        ensure_run(1);
        tick("wrap58");
        cyc(1, 1, 0, 0, 0, 0, "wrap_ca");
        idle("wrap_after");
        idle("wrap_after2");

        cyc(1, 0, 1, 1, 0, 0, "clr_stop");
        minup(9);
        secup(59);
        ensure_run(1);
        cyc(1, 1, 0, 0, 0, 0, "wrap9_ca");
        idle("wrap9_after");

        ensure_run(0);
        cyc(1, 0, 1, 0, 0, 0, "clr");
        minup(12);
        secup(59);
        cyc(1, 0, 0, 0, 0, 1, "sec_nocarry");
        minup(47);
        cyc(1, 0, 0, 0, 1, 0, "min_nocarry");
        cyc(1, 0, 1, 0, 0, 0, "clr");
        minup(5);
        secup(5);
        cyc(1, 0, 0, 0, 1, 1, "both_up");

        cyc(1, 0, 1, 0, 0, 0, "clr");
        secup(10);
        ensure_run(1);
        cyc(1, 1, 0, 0, 0, 1, "tick_mask");
        cyc(1, 1, 1, 0, 0, 1, "clr_prio");
        secup(3);
        cyc(1, 0, 1, 1, 0, 0, "clr_ss");
        tick("stopped_tick");

        minup(34);
        secup(27);
        ensure_run(1);
        idle("pre_rst");
        cyc(0, 1, 0, 0, 0, 0, "mid_rst");
        tick("post_rst_tick");

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 14) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0, "rand");

        if (q.size() != 0) chk("sb_leftover", 16'(q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
